// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : two-requester round-robin arbiter driving an APB memory port.
// Optional ACCESS-phase timeout enabled by defining MEM_ARB_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_sel,
  output logic                  m_enable,
  output logic                  m_wr,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t state_q;
  // Most recent grant; doubles as the owner of the transaction in flight.
  logic   last_q;

  logic w_elig0;
  logic w_elig1;
  logic w_grant_vld;
  logic w_grant_sel;

  assign w_elig0     = req0 & ~ack0;
  assign w_elig1     = req1 & ~ack1;
  assign w_grant_vld = w_elig0 | w_elig1;
  assign w_grant_sel = (w_elig0 & w_elig1) ? ~last_q : w_elig1;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= '0;
      m_sel    <= 1'b0;
      m_enable <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (w_grant_vld) begin
            last_q  <= w_grant_sel;
            m_wr    <= w_grant_sel ? wr1    : wr0;
            m_addr  <= w_grant_sel ? addr1  : addr0;
            m_wdata <= w_grant_sel ? wdata1 : wdata0;
            m_sel   <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          m_enable <= 1'b1;
          state_q  <= S_ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_q    <= '0;
`endif
        end
        S_ACCESS: begin
          if (m_ready) begin
            state_q  <= S_IDLE;
            m_sel    <= 1'b0;
            m_enable <= 1'b0;
            ack0     <= ~last_q;
            ack1     <= last_q;
            if (!m_wr) begin
              rdata <= m_rdata;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          // Abort when this wait cycle would bring the count to TIMEOUT.
          else if (cnt_q == c_cnt_last) begin
            state_q  <= S_IDLE;
            m_sel    <= 1'b0;
            m_enable <= 1'b0;
            ack0     <= ~last_q;
            ack1     <= last_q;
            err_q    <= 1'b1;
            rdata    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : self-checking bench for mem_arbiter with an APB memory slave.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err;
  logic [DW-1:0] rdata;
  logic          m_sel, m_enable, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          rdy;
  logic [DW-1:0] m_rdata;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int            lat, t0, t1, n;
  logic [DW-1:0] rd;
  logic          er;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
    .m_sel(m_sel), .m_enable(m_enable), .m_wr(m_wr),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(rdy), .m_rdata(m_rdata)
  );

  // APB memory slave: 32 words, reset value 8'haa.
  logic [DW-1:0] smem [32];
  assign m_rdata = smem[m_addr];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) smem[i] <= 8'haa;
    end else if (m_sel && m_enable && rdy && m_wr) begin
      smem[m_addr] <= m_wdata;
    end
  end

  // Transaction-level reference model: one transaction in flight, tracked by
  // its phase (1 = setup, 2 = access) and number of wait cycles seen.
  bit          busy, owner, last_g, t_wr;
  int          phase, waits;
  bit [AW-1:0] t_addr;
  bit [DW-1:0] t_wdata;
  bit [DW-1:0] shadow [32];
  bit          e_ack0, e_ack1, e_err, e_sel, e_en, e_wr;
  bit [AW-1:0] e_addr;
  bit [DW-1:0] e_wdata, e_rdata;

  always @(posedge clk) begin : model
    bit pa0, pa1, el0, el1, win, done;
    pa0 = e_ack0;
    pa1 = e_ack1;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_err = 1'b0;
    done = 1'b0;
    if (reset) begin
      busy = 1'b0; phase = 0; waits = 0; last_g = 1'b1;
      e_sel = 1'b0; e_en = 1'b0; e_wr = 1'b0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
      for (int i = 0; i < 32; i++) shadow[i] = 8'haa;
    end else if (!busy) begin
      el0 = req0 && !pa0;
      el1 = req1 && !pa1;
      if (el0 || el1) begin
        win     = (el0 && el1) ? !last_g : el1;
        last_g  = win;
        owner   = win;
        t_wr    = win ? wr1 : wr0;
        t_addr  = win ? addr1 : addr0;
        t_wdata = win ? wdata1 : wdata0;
        busy = 1'b1; phase = 1; waits = 0;
        e_sel = 1'b1; e_wr = t_wr; e_addr = t_addr; e_wdata = t_wdata;
      end
    end else if (phase == 1) begin
      phase = 2;
      e_en  = 1'b1;
    end else if (rdy) begin
      if (t_wr) shadow[t_addr] = t_wdata;
      else      e_rdata = shadow[t_addr];
      done = 1'b1;
    end else begin
      waits++;
`ifdef MEM_ARB_TIMEOUT_EN
      if (waits == TO) begin
        e_err   = 1'b1;
        e_rdata = '0;
        done    = 1'b1;
      end
`endif
    end
    if (done) begin
      busy = 1'b0; phase = 0;
      e_sel = 1'b0; e_en = 1'b0;
      e_ack0 = !owner; e_ack1 = owner;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ({ack0, ack1, err, rdata, m_sel, m_enable, m_wr, m_addr, m_wdata} !==
          {e_ack0, e_ack1, e_err, e_rdata, e_sel, e_en, e_wr, e_addr, e_wdata}) begin
        bad++;
        $display("FAIL model_cmp t=%0t got ack0=%b ack1=%b err=%b rdata=%h sel=%b en=%b wr=%b addr=%h wdata=%h exp ack0=%b ack1=%b err=%b rdata=%h sel=%b en=%b wr=%b addr=%h wdata=%h",
                 $time, ack0, ack1, err, rdata, m_sel, m_enable, m_wr, m_addr, m_wdata,
                 e_ack0, e_ack1, e_err, e_rdata, e_sel, e_en, e_wr, e_addr, e_wdata);
      end
      total++;
      if ((ack0 & ack1) !== 1'b0) begin
        bad++;
        $display("FAIL dual_ack t=%0t got ack0=%b ack1=%b exp not both high", $time, ack0, ack1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // One transaction from an idle arbiter; returns ack latency in edges (-1 if none).
  task automatic xact(input bit who, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int l, output logic [DW-1:0] r,
                      output logic e);
    l = -1; r = '0; e = 1'b0;
    if (who) begin wr1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else     begin wr0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (who ? ack1 : ack0) begin
        l = i; r = rdata; e = err;
      end
      if (i == 1) begin
        if (who) begin wr1 = ~w; addr1 = ~a; wdata1 = ~d; end
        else     begin wr0 = ~w; addr0 = ~a; wdata0 = ~d; end
      end
      if (l >= 0) break;
    end
    if (who) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic contend(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         output int o0, output int o1);
    o0 = -1; o1 = -1;
    wr0 = 1'b0; wr1 = 1'b0; addr0 = a0; addr1 = a1; req0 = 1'b1; req1 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ack0 && o0 < 0) begin o0 = i; req0 = 1'b0; end
      if (ack1 && o1 < 0) begin o1 = i; req1 = 1'b0; end
      if (o0 >= 0 && o1 >= 0) break;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t expired before end of test", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rdy = 1'b1;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    chk("reset_outs", {ack0, ack1, err, rdata, m_sel, m_enable, m_wr, m_addr, m_wdata}, 64'd0);
    reset = 1'b0;
    tick();

    // Lone write, watching the bus phase by phase.
    wr0 = 1'b1; addr0 = 5'h03; wdata0 = 8'hbb; req0 = 1'b1;
    tick();
    chk("setup_bus", {m_sel, m_enable, m_wr, m_addr, m_wdata}, {1'b1, 1'b0, 1'b1, 5'h03, 8'hbb});
    wr0 = 1'b0; addr0 = 5'h1f; wdata0 = 8'h00;
    tick();
    chk("access_bus", {m_sel, m_enable, m_wr, m_addr, m_wdata}, {1'b1, 1'b1, 1'b1, 5'h03, 8'hbb});
    tick();
    chk("write_ack", {ack0, ack1, err, m_sel, m_enable}, 5'b10000);
    req0 = 1'b0;
    tick();

    xact(1'b1, 1'b0, 5'h03, 8'h00, lat, rd, er);
    chk("readback_a3", {lat[7:0], rd, er}, {8'd3, 8'hbb, 1'b0});
    xact(1'b0, 1'b0, 5'h07, 8'h00, lat, rd, er);
    chk("read_a7_default", {lat[7:0], rd, er}, {8'd3, 8'haa, 1'b0});

    // Contention right after reset, repeated.
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    contend(5'h01, 5'h02, t0, t1);
    chk("contend_r1", {t0[7:0], t1[7:0]}, {8'd3, 8'd6});
    tick();
    contend(5'h04, 5'h05, t0, t1);
    chk("contend_r2", {t0[7:0], t1[7:0]}, {8'd3, 8'd6});
    tick();

    // Back-to-back from requester 0.
    wr0 = 1'b0; addr0 = 5'h03; req0 = 1'b1; t0 = -1; t1 = -1; n = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (ack0) begin
        n++;
        if (t0 < 0) t0 = i;
        else begin t1 = i; req0 = 1'b0; end
      end
      if (t1 >= 0) break;
    end
    req0 = 1'b0;
    chk("back_to_back", {t0[7:0], t1[7:0], n[7:0]}, {8'd3, 8'd7, 8'd2});
    tick();

    // Two wait states in ACCESS.
    rdy = 1'b0;
    fork
      xact(1'b0, 1'b1, 5'h0a, 8'h5a, lat, rd, er);
      begin tick(); tick(); tick(); tick(); rdy = 1'b1; end
    join
    chk("wait_state_write", {lat[7:0], er}, {8'd5, 1'b0});
    xact(1'b1, 1'b0, 5'h0a, 8'h00, lat, rd, er);
    chk("wait_state_readback", {lat[7:0], rd, er}, {8'd3, 8'h5a, 1'b0});

    // Reset while in ACCESS.
    rdy = 1'b0; wr0 = 1'b1; addr0 = 5'h09; wdata0 = 8'h11; req0 = 1'b1;
    tick(); tick();
    chk("mid_access_bus", {m_sel, m_enable}, 2'b11);
    reset = 1'b1;
    tick();
    chk("abort_outs", {m_sel, m_enable, ack0, ack1, err}, 5'b00000);
    reset = 1'b0; req0 = 1'b0; rdy = 1'b1; n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack0 || ack1) n++;
    end
    chk("abort_no_ack", n, 0);
    xact(1'b0, 1'b0, 5'h09, 8'h00, lat, rd, er);
    chk("after_abort_read", {lat[7:0], rd, er}, {8'd3, 8'haa, 1'b0});

    // Slave never ready.
    rdy = 1'b0;
    xact(1'b0, 1'b0, 5'h03, 8'h00, lat, rd, er);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("timeout_ack", {lat[7:0], rd, er}, {8'(TO + 2), 8'h00, 1'b1});
`else
    chk("no_timeout_no_ack", lat, -1);
    chk("no_timeout_holds", {m_sel, m_enable}, 2'b11);
    reset = 1'b1; tick(); reset = 1'b0;
`endif
    rdy = 1'b1;
    tick();
    xact(1'b1, 1'b0, 5'h03, 8'h00, lat, rd, er);
    chk("recovery_read", {lat[7:0], rd, er}, {8'd3, 8'haa, 1'b0});

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the write data and read data buses.
REQ-002 Parameter: ADDR_WIDTH, default 5, width of the memory word address.
REQ-003 Parameter: TIMEOUT, default 15, maximum ACCESS-phase wait cycles; used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-004 Port: clk, input, 1, single clock; all logic on rising edge.
REQ-005 Port: reset, input, 1, synchronous, active-high reset.
REQ-006 Port: req0 / req1, input, 1 each, requester N transaction request; held high until ackN.
REQ-007 Port: wr0 / wr1, input, 1 each, 1 = write, 0 = read.
REQ-008 Port: addr0 / addr1, input, ADDR_WIDTH each, requester word address.
REQ-009 Port: wdata0 / wdata1, input, DATA_WIDTH each, requester write data.
REQ-010 Port: ack0 / ack1, output, 1 each, one-cycle completion pulse to requester N.
REQ-011 Port: err, output, 1, qualifies the ack pulse high in the same cycle; 1 = transaction aborted.
REQ-012 Port: rdata, output, DATA_WIDTH, read data; valid in the same cycle as the ack pulse of a read.
REQ-013 Port: m_sel, m_enable, m_wr, output, 1 each, APB select, enable and direction toward mem_block.
REQ-014 Port: m_addr, output, ADDR_WIDTH, APB address toward mem_block.
REQ-015 Port: m_wdata, output, DATA_WIDTH, APB write data toward mem_block.
REQ-016 Port: m_ready, input, 1, APB ready from mem_block.
REQ-017 Port: m_rdata, input, DATA_WIDTH, APB read data from mem_block.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS; all outputs registered.
REQ-019 In IDLE with at least one eligible request, the winner's wr, addr and wdata shall be latched at the clock edge and the FSM shall move to SETUP.
REQ-020 A requester is eligible only when its req is high and its ack is not high in that cycle, so no double grant occurs.
REQ-021 Arbitration is round-robin: with both eligible, the requester not granted last wins; a lone eligible requester always wins.
REQ-022 In SETUP: m_sel=1, m_enable=0, latched addr/wr/wdata driven; the FSM moves to ACCESS unconditionally after one cycle.
REQ-023 In ACCESS: m_sel=1, m_enable=1; the FSM holds in ACCESS while m_ready=0.
REQ-024 When m_ready=1 is sampled in ACCESS: the next cycle has ackN=1 for the winner, err=0, rdata=m_rdata for a read (write: rdata holds its previous value), m_sel=0, m_enable=0, and the FSM in IDLE.
REQ-025 Minimum latency with m_ready already high: req sampled at edge 0, SETUP in cycle 1, ACCESS in cycle 2, ack in cycle 3.
REQ-026 m_addr, m_wr and m_wdata shall stay stable from SETUP through the final ACCESS cycle.
REQ-027 Requester inputs changing after grant shall not affect the transaction in flight.
REQ-028 ack0 and ack1 shall never be high in the same cycle.

Reset
REQ-029 While reset=1 at a rising edge: FSM=IDLE; m_sel, m_enable, m_wr, ack0, ack1 and err = 0; m_addr, m_wdata and rdata = 0; the last-grant pointer is set so req0 wins the first contention.
REQ-030 Reset in SETUP or ACCESS shall abort the transaction with no ack issued.

Configuration
REQ-031 Macro MEM_ARB_TIMEOUT_EN defined: a counter cleared on entering ACCESS increments each ACCESS cycle with m_ready=0.
REQ-032 With MEM_ARB_TIMEOUT_EN, when the count reaches TIMEOUT, the next cycle has ackN=1, err=1, rdata=0, and the FSM in IDLE.
REQ-033 Macro MEM_ARB_TIMEOUT_EN undefined: ACCESS waits indefinitely, no counter is built, and err is tied to 0.

Verification (mem_block DEPTH=32, RESET_VAL=8'haa)
REQ-034 Lone write: req0, wr0=1, addr0=5'h03, wdata0=8'hbb -> SETUP/ACCESS on the m_ bus, ack0 three cycles after req, err=0.
REQ-035 Read-back: req1, read, addr1=5'h03 -> ack1 with rdata=8'hbb; read of addr 5'h07 returns 8'haa.
REQ-036 Contention: req0 and req1 asserted in the same cycle after reset -> requester 0 served first, then 1; a repeat gives 0, 1 order each round.
REQ-037 Back-to-back: req0 held continuously -> consecutive acks four cycles apart, with no double ack and no re-grant in the ack cycle.
REQ-038 Reset mid-ACCESS: reset pulsed while m_enable=1 -> m_sel and m_enable low next cycle, no ack issued, the next request completes normally.
REQ-039 With MEM_ARB_TIMEOUT_EN and m_ready forced 0: ack0 with err=1 and rdata=0 after TIMEOUT ACCESS cycles; without the macro, no ack is issued.
